branch_cond_unit: RTL

Sequential consumer of the ALU status flags. It holds the architectural N/Z/C/V flags register and evaluates 4-bit branch condition codes against those flags. It also computes the next-PC target and presents the registered decision to the fetch stage over a valid/ready handshake. It sits between the ALU flag outputs and the program-counter logic.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/cond_eval.sv | 39 +++
 rtl/branch_cond_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the branch condition unit
// Condition-code encodings, the packed {n,z,c,v} flags type and the output-register states.
package cpu_pkg;

  localparam int DEFAULT_PC_W = 16;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_LO = 4'h2,
    COND_HS = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational branch condition evaluator
// Maps a flags word and a 4-bit condition code to a taken decision.
module cond_eval
  import cpu_pkg::*;
(
  input  flags_t     i_flags,
  input  logic [3:0] i_cond,
  output logic       o_taken
);

  logic w_n_ne_v;

  // C is carry/borrow: after SUB, C=1 means A<B unsigned, so LO is C and HI is !C&!Z.
  assign w_n_ne_v = i_flags.n ^ i_flags.v;

  always_comb begin
    o_taken = 1'b0;
    case (cond_e'(i_cond))
      COND_EQ: o_taken = i_flags.z;
      COND_NE: o_taken = !i_flags.z;
      COND_LO: o_taken = i_flags.c;
      COND_HS: o_taken = !i_flags.c;
      COND_MI: o_taken = i_flags.n;
      COND_PL: o_taken = !i_flags.n;
      COND_VS: o_taken = i_flags.v;
      COND_VC: o_taken = !i_flags.v;
      COND_HI: o_taken = !i_flags.c && !i_flags.z;
      COND_LS: o_taken = i_flags.c || i_flags.z;
      COND_GE: o_taken = !w_n_ne_v;
      COND_LT: o_taken = w_n_ne_v;
      COND_GT: o_taken = !i_flags.z && !w_n_ne_v;
      COND_LE: o_taken = i_flags.z || w_n_ne_v;
      COND_AL: o_taken = 1'b1;
      COND_NV: o_taken = 1'b0;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// rtl/branch_cond_unit.sv - flags register, branch decision and next-PC with valid/ready output
// Optional BRANCH_SHADOW_FLAGS_EN adds flag_save/flag_restore and a 4-bit shadow flags register.
module branch_cond_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = DEFAULT_PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flag_we,
  input  logic            n_in,
  input  logic            z_in,
  input  logic            c_in,
  input  logic            v_in,
  input  logic            ev_valid,
  output logic            ev_ready,
  input  logic [3:0]      cond,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] offset,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            taken,
  output logic [PC_W-1:0] target,
`ifdef BRANCH_SHADOW_FLAGS_EN
  input  logic            flag_save,
  input  logic            flag_restore,
`endif
  output logic [3:0]      flags_q
);

  out_state_e      r_state;
  out_state_e      w_state_nxt;
  flags_t          r_flags;
  flags_t          w_flags_in;
  flags_t          w_flags_wr;
  flags_t          w_flags_nxt;
  logic            w_accept;
  logic            w_load;
  logic            w_taken;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] r_target;
  logic            r_taken;

  assign w_flags_in = '{n: n_in, z: z_in, c: c_in, v: v_in};
  // Flag writes bypass into an evaluation accepted in the same cycle.
  assign w_flags_wr = flag_we ? w_flags_in : r_flags;

`ifdef BRANCH_SHADOW_FLAGS_EN
  flags_t r_shadow;

  // Restore wins over flag_we; save samples pre-restore flags so save+restore swaps.
  assign w_flags_nxt = flag_restore ? r_shadow : w_flags_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (flag_save) begin
      r_shadow <= w_flags_wr;
    end
  end
`else
  assign w_flags_nxt = w_flags_wr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else begin
      r_flags <= w_flags_nxt;
    end
  end

  cond_eval u_cond_eval (
    .i_flags (w_flags_nxt),
    .i_cond  (cond),
    .o_taken (w_taken)
  );

  assign w_target = w_taken ? (pc + offset) : (pc + {{(PC_W-1){1'b0}}, 1'b1});

  assign res_valid = (r_state == ST_FULL);
  assign ev_ready  = !rst && (!res_valid || res_ready);
  assign w_accept  = ev_valid && ev_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_load      = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_accept) begin
          w_load = 1'b1;
        end else if (res_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Result holds until replaced by a new acceptance, so it is stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_taken  <= 1'b0;
      r_target <= '0;
    end else if (w_load) begin
      r_taken  <= w_taken;
      r_target <= w_target;
    end
  end

  assign taken   = r_taken;
  assign target  = r_target;
  assign flags_q = r_flags;

endmodule
